flash_sample_prefetcher: RTL



---
 rtl/flash_sample_prefetcher.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/flash_sample_prefetcher.sv
// Reads little-endian 16-bit PCM samples from 8-bit wait-stated flash into a small
// FIFO and serves them one per consumer request, with silence plus a sticky flag on underrun.
module flash_sample_prefetcher #(
    parameter int unsigned       ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] START_ADDR  = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR    = 23'h24C5E0,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter int unsigned       FIFO_LOG2   = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              enable,
    input  logic              rewind,
    output logic [ADDR_W-1:0] FL_ADDR,
    input  logic [7:0]        FL_DQ,
    input  logic              sample_req,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              underrun,
    input  logic              clr_underrun,
    output logic [FIFO_LOG2:0] fifo_level,
    output logic              wrap
);

    localparam int unsigned         DEPTH     = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]  DEPTH_LVL = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [3:0]          WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, PUSH} state_t;

    state_t              state, state_next;
    logic [3:0]          wait_cnt;
    logic [7:0]          lo_byte, hi_byte;
    logic                cap_lo, cap_hi, push_en, start_fetch;
    logic [ADDR_W:0]     addr_inc;
    logic [FIFO_LOG2:0]  wr_ptr, rd_ptr;
    logic                pop_en;
    logic [15:0]         mem [DEPTH];

    // NOTE: every flop below uses <= so all registers see pre-edge values, whatever the block order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: all outputs get a default first, so no path through the case leaves one unassigned (no latch).
    always_comb begin
        state_next  = state;
        cap_lo      = 1'b0;
        cap_hi      = 1'b0;
        push_en     = 1'b0;
        start_fetch = 1'b0;
        case (state)
            IDLE: if (enable && fifo_level < DEPTH_LVL) begin
                start_fetch = 1'b1;
                state_next  = FETCH_LO;
            end
            FETCH_LO: if (wait_cnt == WAIT_LAST) begin
                cap_lo     = 1'b1;
                state_next = FETCH_HI;
            end
            FETCH_HI: if (wait_cnt == WAIT_LAST) begin
                cap_hi     = 1'b1;
                state_next = PUSH;
            end
            PUSH: begin
                push_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A rewind aborts whatever the fetch engine was about to do.
        if (rewind) begin
            state_next  = IDLE;
            cap_lo      = 1'b0;
            cap_hi      = 1'b0;
            push_en     = 1'b0;
            start_fetch = 1'b0;
        end
    end

    assign addr_inc = {1'b0, FL_ADDR} + 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt <= '0;
            lo_byte  <= '0;
            hi_byte  <= '0;
            FL_ADDR  <= START_ADDR;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (rewind || start_fetch || cap_lo || cap_hi || state == IDLE || state == PUSH)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;

            if (rewind) begin
                FL_ADDR <= START_ADDR;
            end else if (cap_lo) begin
                lo_byte <= FL_DQ;
                FL_ADDR <= addr_inc[ADDR_W-1:0];
            end else if (cap_hi) begin
                hi_byte <= FL_DQ;
                if (addr_inc >= {1'b0, END_ADDR}) begin
                    FL_ADDR <= START_ADDR;
                    wrap    <= 1'b1;
                end else begin
                    FL_ADDR <= addr_inc[ADDR_W-1:0];
                end
            end
        end
    end

    // A request during rewind, or against an empty FIFO, is served as an underrun.
    assign fifo_level = wr_ptr - rd_ptr;
    assign pop_en     = sample_req && !rewind && (fifo_level != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (rewind) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge Clk) begin
        if (push_en) mem[wr_ptr[FIFO_LOG2-1:0]] <= {hi_byte, lo_byte};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= sample_req;
            if (pop_en)
                sample_out <= mem[rd_ptr[FIFO_LOG2-1:0]];
            else if (sample_req)
                sample_out <= 16'h0000;

            if (sample_req && !pop_en) underrun <= 1'b1;
            else if (clr_underrun)     underrun <= 1'b0;
        end
    end

endmodule
